// File: rtl/core_pkg.sv
// Shared definitions for the ID-stage multiport register file.
//
// Contents:
//   DATA_WIDTH      default register width in bits
//   NUM_REGS        default number of architectural registers (x0 reads as zero)
//   REG_ADDR_WIDTH  register address width for the default NUM_REGS
//   rf_state_e      register file sequencing states (post-reset clear / ready)
package core_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int NUM_REGS       = 32;
  localparam int REG_ADDR_WIDTH = $clog2(NUM_REGS);

  typedef enum logic {
    RF_CLEAR,
    RF_READY
  } rf_state_e;

endpackage

// File: rtl/multiport_register_file_scoreboard.sv
// rf_scoreboard: one busy bit per architectural register.
//
// A bit is set by a destination allocation at issue and cleared when
// writeback writes that register. If an allocation and a write land on the
// same register in the same cycle, the allocation wins and the bit stays set.
// x0 is never busy. All bits are cleared while the register file is clearing.
//
// Ports:
//   clk         clock
//   rst_n       synchronous active-low reset
//   clear       register file is in its clear sequence
//   alloc_en    allocate alloc_addr this cycle
//   alloc_addr  register to mark busy
//   wr_en       effective write enables (already qualified by the ready state)
//   wr_addr     write addresses
//   rd_addr     read port addresses
//   rd_hit      read port is being served by a same-cycle write bypass
//   rd_busy     busy flag per read port
module rf_scoreboard #(
  parameter int NUM_REGS     = 32,
  parameter int NUM_RD_PORTS = 2,
  parameter int NUM_WR_PORTS = 2,
  parameter int ADDR_W       = 5
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 alloc_en,
  input  logic [ADDR_W-1:0]                    alloc_addr,
  input  logic [NUM_WR_PORTS-1:0]              wr_en,
  input  logic [NUM_WR_PORTS-1:0][ADDR_W-1:0]  wr_addr,
  input  logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]  rd_addr,
  input  logic [NUM_RD_PORTS-1:0]              rd_hit,
  output logic [NUM_RD_PORTS-1:0]              rd_busy
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_next;

  always_comb begin
    busy_next = busy;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      if (wr_en[p]) busy_next[wr_addr[p]] = 1'b0;
    end
    // allocation is applied last so it overrides a same-cycle write
    if (alloc_en) busy_next[alloc_addr] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

  always_comb begin
    rd_busy = '0;
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      rd_busy[r] = busy[rd_addr[r]] && !rd_hit[r] && (rd_addr[r] != '0);
    end
  end

endmodule

// File: rtl/multiport_register_file.sv
// multiport_register_file: ID-stage integer register file for dual-issue cores.
//
// Writeback writes it through NUM_WR_PORTS ports (higher index wins on an
// address collision); decode reads it through NUM_RD_PORTS combinational
// ports with same-cycle write-to-read bypass. x0 always reads zero and is
// never written or bypassed. The array carries no reset: after rst_n a
// sequential engine zeroes x1..x(NUM_REGS-1), one register per cycle, and
// ready_o rises when it is done. Writes are ignored and reads return zero
// until then.
//
// Optional build macro RF_SCOREBOARD_EN adds a per-register busy scoreboard
// (alloc_en_i, alloc_addr_i, rd_busy_o).
//
// Ports:
//   clk           clock, all state updates on posedge
//   rst_n         synchronous active-low reset
//   rd_addr_i     read addresses, one per read port
//   rd_data_o     read data, one per read port
//   wr_en_i       write enables, one per write port
//   wr_addr_i     write addresses
//   wr_data_i     write data
//   ready_o       clear sequence complete
//   alloc_en_i    (RF_SCOREBOARD_EN) destination allocation at issue
//   alloc_addr_i  (RF_SCOREBOARD_EN) register to allocate
//   rd_busy_o     (RF_SCOREBOARD_EN) busy flag per read port
//
// States:
//   RF_CLEAR | zeroing registers[clr_idx], one per cycle; writes ignored, reads 0
//   RF_READY | normal operation until the next reset
module multiport_register_file #(
  parameter int  DATA_WIDTH   = core_pkg::DATA_WIDTH,
  parameter int  NUM_REGS     = core_pkg::NUM_REGS,
  parameter int  NUM_RD_PORTS = 2,
  parameter int  NUM_WR_PORTS = 2,
  localparam int ADDR_W       = $clog2(NUM_REGS)
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_RD_PORTS-1:0][ADDR_W-1:0]     rd_addr_i,
  output logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0] rd_data_o,
  input  logic [NUM_WR_PORTS-1:0]                 wr_en_i,
  input  logic [NUM_WR_PORTS-1:0][ADDR_W-1:0]     wr_addr_i,
  input  logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0] wr_data_i,
  output logic                                    ready_o
`ifdef RF_SCOREBOARD_EN
  ,
  input  logic                                    alloc_en_i,
  input  logic [ADDR_W-1:0]                       alloc_addr_i,
  output logic [NUM_RD_PORTS-1:0]                 rd_busy_o
`endif
);

  import core_pkg::*;

  rf_state_e             state;
  rf_state_e             state_next;
  logic [ADDR_W-1:0]     clr_idx;
  logic [ADDR_W-1:0]     clr_idx_next;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_WR_PORTS-1:0] wr_act;
  logic [NUM_RD_PORTS-1:0] rd_hit;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= RF_CLEAR;
      clr_idx <= ADDR_W'(1);
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    case (state)
      RF_CLEAR: begin
        if (clr_idx == LAST_IDX) begin
          state_next = RF_READY;
        end else begin
          clr_idx_next = clr_idx + ADDR_W'(1);
        end
      end
      RF_READY: state_next = RF_READY;
      default:  state_next = RF_CLEAR;
    endcase
  end

  assign ready_o = (state == RF_READY);

  // writes that actually take effect: ready, enabled, not x0
  always_comb begin
    wr_act = '0;
    for (int p = 0; p < NUM_WR_PORTS; p++) begin
      wr_act[p] = ready_o && wr_en_i[p] && (wr_addr_i[p] != '0);
    end
  end

  // later (higher-index) ports are assigned last, so they win collisions
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == RF_CLEAR) begin
        regs[clr_idx] <= '0;
      end else begin
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
          if (wr_act[p]) regs[wr_addr_i[p]] <= wr_data_i[p];
        end
      end
    end
  end

  always_comb begin
    rd_data_o = '0;
    rd_hit    = '0;
    for (int r = 0; r < NUM_RD_PORTS; r++) begin
      if (ready_o && rd_addr_i[r] != '0) begin
        rd_data_o[r] = regs[rd_addr_i[r]];
        for (int p = 0; p < NUM_WR_PORTS; p++) begin
          if (wr_act[p] && wr_addr_i[p] == rd_addr_i[r]) begin
            rd_hit[r]    = 1'b1;
            rd_data_o[r] = wr_data_i[p];
          end
        end
      end
    end
  end

`ifdef RF_SCOREBOARD_EN
  rf_scoreboard #(
    .NUM_REGS     (NUM_REGS),
    .NUM_RD_PORTS (NUM_RD_PORTS),
    .NUM_WR_PORTS (NUM_WR_PORTS),
    .ADDR_W       (ADDR_W)
  ) u_scoreboard (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (state == RF_CLEAR),
    .alloc_en   (alloc_en_i),
    .alloc_addr (alloc_addr_i),
    .wr_en      (wr_act),
    .wr_addr    (wr_addr_i),
    .rd_addr    (rd_addr_i),
    .rd_hit     (rd_hit),
    .rd_busy    (rd_busy_o)
  );
`endif

endmodule

// File: doc/multiport_register_file.md
Name: multiport_register_file

Overview:
Parametrised successor of the ID-stage integer register file for dual-issue cores.
- Configurable number of read and write ports, with deterministic write-port priority and same-cycle write-to-read bypass.
- Sequential post-reset clear engine, so the array needs no per-bit reset.
- Sits in ID: WB writes it, decode reads it.

Parameters:
DATA_WIDTH, 32, register width in bits
NUM_REGS, 32, architectural registers; x0 hardwired to zero; must be a power of two, >= 2
NUM_RD_PORTS, 2, independent combinational read ports
NUM_WR_PORTS, 2, write ports; higher index = higher priority
ADDR_W, $clog2(NUM_REGS), derived; not overridable

Ports:
clk  in  1  clock; all state updates on posedge
rst_n  in  1  synchronous active-low reset
rd_addr_i  in  NUM_RD_PORTS x ADDR_W  read addresses
rd_data_o  out  NUM_RD_PORTS x DATA_WIDTH  read data
wr_en_i  in  NUM_WR_PORTS  write enables
wr_addr_i  in  NUM_WR_PORTS x ADDR_W  write addresses
wr_data_i  in  NUM_WR_PORTS x DATA_WIDTH  write data
ready_o  out  1  high once the clear sequence is complete

Behaviour:
- Reset and clock: one clock, clk; reset rst_n is synchronous, active-low.
- rst_n=0 at a posedge: state<=CLEAR, clr_idx<=1, ready_o=0.
  - Array contents are not reset directly.
- CLEAR state:
  - Each cycle writes 0 to registers[clr_idx], then clr_idx++.
  - When clr_idx==NUM_REGS-1 has been written, next state is READY.
  - Clear takes NUM_REGS-1 cycles after rst_n rises (31 at default).
  - wr_en_i is ignored. All rd_data_o = 0. ready_o = 0.
- READY state: ready_o=1 (registered); stays READY until the next reset.
- Reset mid-clear restarts at clr_idx=1. Reset in READY re-enters CLEAR.
- Write (READY only): on posedge, for each port p with wr_en_i[p] && wr_addr_i[p]!=0, registers[wr_addr_i[p]] <= wr_data_i[p].
  - Same-address collision: highest-index enabled port wins; lower ports are dropped silently.
- Read (combinational, 0 latency):
  - Address 0 returns 0.
  - Otherwise, if any enabled write port targets the same non-zero address this cycle, return that port's wr_data_i, using the same priority as the write.
  - Otherwise return the array value.
  - Every read port sees the same bypass.
- Writes to x0 are never stored and never bypassed.

Optional Feature:
Macro RF_SCOREBOARD_EN.
- Defined adds ports:
  - alloc_en_i (in, 1): destination allocation at issue.
  - alloc_addr_i (in, ADDR_W): register to allocate.
  - rd_busy_o (out, NUM_RD_PORTS): busy flag per read port.
- Busy bit per register:
  - Set on posedge when alloc_en_i and alloc_addr_i!=0.
  - Cleared when any enabled write port writes that register.
  - Same-cycle alloc and write to the same register: alloc wins, bit stays 1.
- rd_busy_o[r] = busy[rd_addr_i[r]] && !(bypass hit on rd_addr_i[r]); always 0 for x0.
- All busy bits clear while in CLEAR. alloc_en_i is ignored during CLEAR.
- Undefined: ports absent, no busy state.

Decomposition:
- core_pkg holds DATA_WIDTH, NUM_REGS, REG_ADDR_WIDTH, and typedef enum logic {RF_CLEAR, RF_READY} rf_state_e.
- One sub-module is natural: rf_scoreboard (busy-bit array with set/clear and per-port lookup), instantiated only under RF_SCOREBOARD_EN.
- Bypass mux and priority logic stay inline.

Test Plan:
- Clear sequence: hold rst_n=0 for 2 cycles, release -> ready_o=0 for exactly 31 cycles, then 1; every reg reads 0; a write of x5=0xDEAD during clear leaves x5=0.
- Write/read: write x5=0x12345678 on port 0 -> same cycle rd_data_o[1]=0x12345678 via bypass; next cycle the array read also returns 0x12345678; any write to x0 -> reads 0.
- Collision: port0 x7=0xAAAA and port1 x7=0xBBBB in one cycle -> bypass and stored value are 0xBBBB.
- Mid-clear reset: assert rst_n=0 at clr_idx=10, release -> clear restarts and ready_o rises 31 cycles after release.
- RF_SCOREBOARD_EN:
  - alloc x3 -> rd_busy_o=1 for x3 next cycle.
  - Write x3 -> busy drops the same cycle via bypass and stays 0.
  - Alloc and write x3 in the same cycle -> busy remains 1.
